// File: rtl/piso_ser8_if.sv
// Load/serial bus of the 8-bit parallel-in serial-out block.
// Ports (signals):
//   d          [7:0] parallel word from upstream
//   load_valid       upstream requests capture of d
//   load_ready       serializer can accept d this cycle
//   sout             serial data bit
//   sout_valid       sout carries a frame bit
//   frame_done       pulse with the last bit of a frame
// master = upstream word source, slave = serializer.
interface piso_ser8_if;
  logic [7:0] d;
  logic       load_valid;
  logic       load_ready;
  logic       sout;
  logic       sout_valid;
  logic       frame_done;

  modport master (
    output d, load_valid,
    input  load_ready, sout, sout_valid, frame_done
  );

  modport slave (
    input  d, load_valid,
    output load_ready, sout, sout_valid, frame_done
  );
endinterface

// File: rtl/piso_ser8.sv
// 8-bit parallel-in serial-out shifter with optional even-parity bit.
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-high reset
//   bus  piso_ser8_if.slave: d/load_valid in, load_ready/sout/sout_valid/frame_done out
// sout, sout_valid and frame_done are registered; load_ready is decoded
// from state so a new word can be taken in the last-bit cycle.
module piso_ser8 #(
  parameter bit MSB_FIRST = 1'b1,
  parameter bit PARITY_EN = 1'b0
) (
  input logic       clk,
  input logic       rst,
  piso_ser8_if.slave bus
);

  localparam int unsigned DATA_W = 8;
  localparam int unsigned CNT_W  = 3;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DATA_W - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    PAR   = 2'd2
  } state_t;

  state_t              state, state_n;
  logic [CNT_W-1:0]    cnt, cnt_n;
  logic [DATA_W-1:0]   shreg, shreg_n;
  logic                par, par_n;
  logic                sout_q, sout_n;
  logic                valid_q, valid_n;
  logic                done_q, done_n;
  logic                last_bit;
  logic                accept;

  // Cycle currently presenting the final bit of a frame.
  assign last_bit = ((state == SHIFT) && (cnt == LAST_IDX) && !PARITY_EN) ||
                    (state == PAR);

  assign bus.load_ready = !rst && ((state == IDLE) || last_bit);
  assign accept         = bus.load_valid && bus.load_ready;

  assign bus.sout       = sout_q;
  assign bus.sout_valid = valid_q;
  assign bus.frame_done = done_q;

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      shreg   <= '0;
      par     <= 1'b0;
      sout_q  <= 1'b0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      shreg   <= shreg_n;
      par     <= par_n;
      sout_q  <= sout_n;
      valid_q <= valid_n;
      done_q  <= done_n;
    end
  end

  // Next-state and next-output logic. The first bit of a word is pulled
  // straight from d at the accepting edge so it appears one cycle later;
  // shreg then holds the remaining bits with the next one at the exit end.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    shreg_n = shreg;
    par_n   = par;
    sout_n  = 1'b0;
    valid_n = 1'b0;
    done_n  = 1'b0;

    unique case (state)
      SHIFT: begin
        if (cnt != LAST_IDX) begin
          cnt_n   = CNT_W'(cnt + CNT_W'(1));
          valid_n = 1'b1;
          done_n  = (cnt == CNT_W'(DATA_W - 2)) && !PARITY_EN;
          if (MSB_FIRST) begin
            sout_n  = shreg[DATA_W-1];
            shreg_n = {shreg[DATA_W-2:0], 1'b0};
          end else begin
            sout_n  = shreg[0];
            shreg_n = {1'b0, shreg[DATA_W-1:1]};
          end
        end else if (PARITY_EN) begin
          state_n = PAR;
          sout_n  = par;
          valid_n = 1'b1;
          done_n  = 1'b1;
        end else begin
          state_n = IDLE;
          cnt_n   = '0;
        end
      end
      PAR: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase

    // A new word overrides the return to IDLE (from IDLE or the last bit).
    if (accept) begin
      state_n = SHIFT;
      cnt_n   = '0;
      par_n   = ^bus.d;
      valid_n = 1'b1;
      done_n  = 1'b0;
      if (MSB_FIRST) begin
        sout_n  = bus.d[DATA_W-1];
        shreg_n = {bus.d[DATA_W-2:0], 1'b0};
      end else begin
        sout_n  = bus.d[0];
        shreg_n = {1'b0, bus.d[DATA_W-1:1]};
      end
    end
  end

endmodule

// File: tb/tb_piso_ser8.sv
// Bench for piso_ser8: three instances (MSB-first, LSB-first, MSB-first with
// parity) share one stimulus; each output nibble is {sout,sout_valid,frame_done,load_ready}.
module tb_piso_ser8;

  typedef struct {
    logic [7:0] d;
    logic [7:0] seq_msb; // emitted order, first bit in [7]
    logic [7:0] seq_lsb; // emitted order, first bit in [7]
    logic       parity;
  } vec_t;

  logic       clk;
  logic       rst;
  logic [7:0] d;
  logic       load_valid;
  int         checks;
  int         errors;

  piso_ser8_if ifa ();
  piso_ser8_if ifb ();
  piso_ser8_if ifc ();

  assign ifa.d = d;  assign ifa.load_valid = load_valid;
  assign ifb.d = d;  assign ifb.load_valid = load_valid;
  assign ifc.d = d;  assign ifc.load_valid = load_valid;

  piso_ser8 #(.MSB_FIRST(1'b1), .PARITY_EN(1'b0)) dut_a (.clk(clk), .rst(rst), .bus(ifa));
  piso_ser8 #(.MSB_FIRST(1'b0), .PARITY_EN(1'b0)) dut_b (.clk(clk), .rst(rst), .bus(ifb));
  piso_ser8 #(.MSB_FIRST(1'b1), .PARITY_EN(1'b1)) dut_c (.clk(clk), .rst(rst), .bus(ifc));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  function automatic logic [3:0] obs_a();
    return {ifa.sout, ifa.sout_valid, ifa.frame_done, ifa.load_ready};
  endfunction
  function automatic logic [3:0] obs_b();
    return {ifb.sout, ifb.sout_valid, ifb.frame_done, ifb.load_ready};
  endfunction
  function automatic logic [3:0] obs_c();
    return {ifc.sout, ifc.sout_valid, ifc.frame_done, ifc.load_ready};
  endfunction

  // Expected nibble k cycles after acceptance, 8-bit frame.
  function automatic logic [3:0] exp8(logic [7:0] seq, int k);
    if (k < 8) return {seq[3'(7 - k)], 1'b1, k == 7, k == 7};
    return 4'b0001;
  endfunction

  // Expected nibble k cycles after acceptance, 9-bit frame.
  function automatic logic [3:0] exp9(logic [7:0] seq, logic p, int k);
    if (k < 8)  return {seq[3'(7 - k)], 1'b1, 1'b0, 1'b0};
    if (k == 8) return {p, 1'b1, 1'b1, 1'b1};
    return 4'b0001;
  endfunction

  task automatic chk(input string name, input int k, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc %0d got %b want %b (sout,valid,done,ready)", name, k, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Load one word, then scramble d so only the captured value may show.
  task automatic run_frame(input vec_t v, input int idx);
    d = v.d;
    load_valid = 1'b1;
    tick();
    load_valid = 1'b0;
    d = ~v.d;
    for (int k = 0; k < 10; k++) begin
      chk($sformatf("vec%0d_msb", idx), k, obs_a(), exp8(v.seq_msb, k));
      chk($sformatf("vec%0d_lsb", idx), k, obs_b(), exp8(v.seq_lsb, k));
      chk($sformatf("vec%0d_par", idx), k, obs_c(), exp9(v.seq_msb, v.parity, k));
      tick();
    end
  endtask

  vec_t vecs [5];

  initial begin
    vecs[0] = '{d: 8'hA5, seq_msb: 8'hA5, seq_lsb: 8'hA5, parity: 1'b0};
    vecs[1] = '{d: 8'h01, seq_msb: 8'h01, seq_lsb: 8'h80, parity: 1'b1};
    vecs[2] = '{d: 8'h3C, seq_msb: 8'h3C, seq_lsb: 8'h3C, parity: 1'b0};
    vecs[3] = '{d: 8'hC8, seq_msb: 8'hC8, seq_lsb: 8'h13, parity: 1'b1};
    vecs[4] = '{d: 8'hFF, seq_msb: 8'hFF, seq_lsb: 8'hFF, parity: 1'b0};

    checks = 0;
    errors = 0;
    rst = 1'b1;
    d = 8'h00;
    load_valid = 1'b0;

    // Reset state, before and after clock edges; ready low under reset.
    #3;
    chk("rst_a", 0, obs_a(), 4'b0000);
    chk("rst_b", 0, obs_b(), 4'b0000);
    chk("rst_c", 0, obs_c(), 4'b0000);
    tick();
    tick();
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rel_a", 0, obs_a(), 4'b0001);
    chk("rel_b", 0, obs_b(), 4'b0001);
    chk("rel_c", 0, obs_c(), 4'b0001);
    tick();

    for (int i = 0; i < 5; i++) run_frame(vecs[i], i);

    // Back-to-back: FF then 00 with load_valid held; busy-cycle requests ignored.
    d = 8'hFF;
    load_valid = 1'b1;
    tick();
    for (int k = 0; k < 19; k++) begin
      chk("b2b_msb", k, obs_a(),
          {k < 8, k < 16, (k == 7) || (k == 15), (k == 7) || (k >= 15)});
      chk("b2b_lsb", k, obs_b(),
          {k < 8, k < 16, (k == 7) || (k == 15), (k == 7) || (k >= 15)});
      chk("b2b_par", k, obs_c(),
          {k < 8, k < 18, (k == 8) || (k == 17), (k == 8) || (k >= 17)});
      if (k == 0) d = 8'h00;
      if (k == 9) load_valid = 1'b0;
      tick();
    end

    // Reset between edges during bit 4, then a clean frame.
    d = 8'hFF;
    load_valid = 1'b1;
    tick();
    load_valid = 1'b0;
    tick();
    tick();
    tick();
    chk("pre_rst_a", 3, obs_a(), 4'b1100);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_a", 0, obs_a(), 4'b0000);
    chk("mid_rst_b", 0, obs_b(), 4'b0000);
    chk("mid_rst_c", 0, obs_c(), 4'b0000);
    tick();
    chk("hold_rst_a", 1, obs_a(), 4'b0000);
    chk("hold_rst_b", 1, obs_b(), 4'b0000);
    chk("hold_rst_c", 1, obs_c(), 4'b0000);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rel2_a", 0, obs_a(), 4'b0001);
    chk("rel2_b", 0, obs_b(), 4'b0001);
    chk("rel2_c", 0, obs_c(), 4'b0001);
    tick();
    run_frame(vecs[2], 5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/piso_ser8.md
PISO_SER8 -- requirements
Module: piso_ser8

Interface
REQ-001 Parameter: MSB_FIRST, default 1, 1 = bit 7 shifted first and 0 = bit 0 shifted first.
REQ-002 Parameter: PARITY_EN, default 0, 1 = an even-parity bit is appended after the 8 data bits.
REQ-003 Port: clk  input  1  single clock; all state changes on its rising edge.
REQ-004 Port: rst  input  1  asynchronous, active-high reset.
REQ-005 Port: d  input  8  parallel word, fed by the upstream 8-bit async-reset register q.
REQ-006 Port: load_valid  input  1  upstream requests capture of d.
REQ-007 Port: load_ready  output  1  block can accept d this cycle.
REQ-008 Port: sout  output  1  serial data bit, registered.
REQ-009 Port: sout_valid  output  1  sout carries a frame bit this cycle, registered.
REQ-010 Port: frame_done  output  1  one-cycle pulse, high together with the last bit of a frame, registered.

Function
REQ-011 The block SHALL use the FSM states IDLE, SHIFT and PAR, plus a 3-bit bit counter and an 8-bit shift register.
REQ-012 A load SHALL be accepted on a rising clk edge where load_valid=1 and load_ready=1; at that edge d is captured and the state goes to SHIFT.
REQ-013 Latency: the first bit SHALL appear on sout with sout_valid=1 in the cycle immediately after the accepting edge.
REQ-014 Bit order: in SHIFT, sout SHALL present one data bit per cycle for 8 consecutive cycles, in the order set by MSB_FIRST.
REQ-015 Parity: with PARITY_EN=1, SHIFT SHALL go to PAR after bit 8, and for one cycle sout = XOR of the 8 captured bits (even parity) with sout_valid=1.
REQ-016 Frame length: a frame SHALL be 8 valid cycles, or 9 with PARITY_EN=1; sout_valid SHALL have no gaps inside a frame.
REQ-017 frame_done SHALL be high exactly in the cycle carrying the last frame bit (bit 8, or the parity bit) and low in all other cycles.
REQ-018 load_ready SHALL be 1 in IDLE and in the last-bit cycle of a frame, and 0 in all other cycles.
REQ-019 Back-to-back: a load accepted in the last-bit cycle SHALL put the first bit of the new frame on sout in the next cycle, with sout_valid continuously 1 across the two frames.
REQ-020 After the last bit with no new load, the state SHALL return to IDLE with sout_valid=0 and sout=0.
REQ-021 load_valid while load_ready=0 SHALL be ignored: the word being shifted is unchanged and nothing is queued.
REQ-022 d SHALL be sampled only at the accepting edge; changes on d afterwards SHALL not affect the current frame.
REQ-023 While sout_valid=0, sout SHALL be 0.

Reset
REQ-024 While rst=1, regardless of clk: state=IDLE, counter=0, shift register=0, sout=0, sout_valid=0, frame_done=0.
REQ-025 While rst=1, load_ready SHALL be 0; it SHALL become 1 combinationally once rst=0.
REQ-026 Reset mid-frame SHALL abort the frame immediately; no frame_done is issued and the first load after reset starts a clean frame.

Verification
REQ-027 Scenario 1: MSB_FIRST=1, PARITY_EN=0, load d=8'hA5 -> sout 1,0,1,0,0,1,0,1 on 8 consecutive valid cycles; frame_done on the 8th; load_ready high in that cycle and in IDLE afterwards.
REQ-028 Scenario 2: MSB_FIRST=0, load d=8'h01 -> sout 1,0,0,0,0,0,0,0; sout_valid high for exactly 8 cycles.
REQ-029 Scenario 3: PARITY_EN=1, d=8'h01 -> 9 valid cycles, parity bit 1; d=8'hA5 -> parity bit 0; frame_done on the 9th cycle.
REQ-030 Scenario 4: load d=8'hFF, hold load_valid=1 with d=8'h00 -> second frame starts the cycle after the first frame's last bit; sout_valid stays high for 16 cycles; load_valid during busy cycles is ignored.
REQ-031 Scenario 5: rst=1 asserted between clock edges at bit 4 -> all outputs 0 immediately, no frame_done; after release, load d=8'h3C -> full, correct frame 0,0,1,1,1,1,0,0 (MSB first).
REQ-032 Scenario 6: change d during SHIFT -> serialized bits match the value captured at acceptance.
